// File: rtl/arb_rr_bin_grant.sv
// Round-robin arbiter with a registered binary grant index and a valid/ready
// handshake. The pointer advances past the granted requester only on acceptance.
module arb_rr_bin_grant #(
  parameter int REQ_NUM = 8,
  parameter int IDX_WTH = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [REQ_NUM-1:0] req_i,
  output logic               gnt_vld_o,
  output logic [IDX_WTH-1:0] gnt_idx_o,
  input  logic               gnt_rdy_i,
  output logic               busy_o
);

  localparam int unsigned CW = IDX_WTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_WTH-1:0] ptr;
  logic [IDX_WTH-1:0] ptr_adv;
  logic [IDX_WTH-1:0] arb_base;
  logic [IDX_WTH-1:0] winner;
  logic [CW-1:0]      cand;
  logic               found;
  logic               any_req;

  assign any_req = |req_i;
  assign ptr_adv = (gnt_idx_o == IDX_WTH'(REQ_NUM - 1)) ? '0 : gnt_idx_o + 1'b1;

  // A back-to-back grant must already see the pointer it is about to get.
  assign arb_base = (state == HOLD) ? ptr_adv : ptr;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      cand = {1'b0, arb_base} + CW'(i);
      if (cand >= CW'(REQ_NUM)) begin
        cand = cand - CW'(REQ_NUM);
      end
      if (!found && req_i[cand[IDX_WTH-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_WTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      gnt_vld_o <= 1'b0;
      busy_o    <= 1'b0;
      gnt_idx_o <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= HOLD;
            gnt_vld_o <= 1'b1;
            busy_o    <= 1'b1;
            gnt_idx_o <= winner;
          end
        end
        HOLD: begin
          if (gnt_rdy_i) begin
            ptr <= ptr_adv;
            if (any_req) begin
              gnt_idx_o <= winner;
            end else begin
              state     <= IDLE;
              gnt_vld_o <= 1'b0;
              busy_o    <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          gnt_vld_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_rr_bin_grant.sv
// Bench for arb_rr_bin_grant: directed scenarios plus random traffic against a
// modulo-arithmetic reference model, for an 8-requester and a 5-requester instance.
module tb_arb_rr_bin_grant;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] req8 = '0;
  logic [4:0] req5 = '0;

  logic       vld8, busy8, vld5, busy5;
  logic [2:0] idx8, idx5;

  int errors = 0;
  int checks = 0;

  bit m8_vld, m5_vld;
  int m8_idx, m8_ptr, m5_idx, m5_ptr;

  always #5 clk = ~clk;

  arb_rr_bin_grant #(.REQ_NUM(8), .IDX_WTH(3)) u8 (
    .clk_i(clk), .rst_i(rst), .req_i(req8), .gnt_vld_o(vld8),
    .gnt_idx_o(idx8), .gnt_rdy_i(rdy), .busy_o(busy8)
  );

  arb_rr_bin_grant #(.REQ_NUM(5), .IDX_WTH(3)) u5 (
    .clk_i(clk), .rst_i(rst), .req_i(req5), .gnt_vld_o(vld5),
    .gnt_idx_o(idx5), .gnt_rdy_i(rdy), .busy_o(busy5)
  );

  // First requesting index walking ptr, ptr+1, ... modulo n.
  function automatic int winner(input int n, input int p, input logic [7:0] r);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (p + k) % n;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_step(input int n, input bit r_st, input logic [7:0] r,
                                     input bit rd, inout bit v, inout int idx, inout int p);
    logic [7:0] m;
    m = r & 8'((1 << n) - 1);
    if (r_st) begin
      v = 0; idx = 0; p = 0;
    end else if (!v) begin
      if (m != 0) begin
        v = 1; idx = winner(n, p, m);
      end
    end else if (rd) begin
      p = (idx + 1) % n;
      if (m != 0) idx = winner(n, p, m);
      else v = 0;
    end
  endfunction

  task automatic drive(input bit r_st, input logic [7:0] r, input bit rd);
    rst  = r_st;
    req8 = r;
    req5 = r[4:0];
    rdy  = rd;
    @(posedge clk);
    model_step(8, r_st, r, rd, m8_vld, m8_idx, m8_ptr);
    model_step(5, r_st, r, rd, m5_vld, m5_idx, m5_ptr);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 8'hFF, 1'b0);
    drive(1'b1, 8'hFF, 1'b1);
    drive(1'b1, 8'hFF, 1'b1);
    checks++;
    if (vld8 !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", vld8); end
    checks++;
    if (idx8 !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx8); end
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    checks++;
    if (vld5 !== 1'b0 || idx5 !== 3'd0) begin
      errors++; $display("FAIL reset_u5 got vld=%b idx=%0d exp vld=0 idx=0", vld5, idx5);
    end
  endtask

  task automatic test_single;
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h04, 1'b1);
    checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd2 || busy8 !== 1'b1) begin
      errors++; $display("FAIL single_grant got vld=%b idx=%0d busy=%b exp 1/2/1", vld8, idx8, busy8);
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (vld8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL single_idle got vld=%b busy=%b exp 0/0", vld8, busy8);
    end
    checks++;
    if (idx8 !== 3'd2) begin errors++; $display("FAIL idle_idx_hold got=%0d exp=2", idx8); end
    drive(1'b0, 8'h09, 1'b0);
    checks++;
    if (idx8 !== 3'd3) begin errors++; $display("FAIL ptr_after_single got=%0d exp=3", idx8); end
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 8'hFF, 1'b1);
      checks++;
      if (vld8 !== 1'b1 || idx8 !== 3'(k % 8)) begin
        errors++; $display("FAIL b2b_seq[%0d] got vld=%b idx=%0d exp vld=1 idx=%0d", k, vld8, idx8, k % 8);
      end
    end
  endtask

  task automatic test_hold;
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h81, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if (vld8 !== 1'b1 || idx8 !== 3'd0) begin
        errors++; $display("FAIL hold_stable[%0d] got vld=%b idx=%0d exp 1/0", k, vld8, idx8);
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (vld8 !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", vld8); end
  endtask

  task automatic test_wrap;
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h40, 1'b0);
    drive(1'b0, 8'h81, 1'b1);
    checks++;
    if (idx8 !== 3'd7 || vld8 !== 1'b1) begin
      errors++; $display("FAIL wrap_to7 got vld=%b idx=%0d exp 1/7", vld8, idx8);
    end
    drive(1'b0, 8'h81, 1'b1);
    checks++;
    if (idx8 !== 3'd0 || vld8 !== 1'b1) begin
      errors++; $display("FAIL wrap_to0 got vld=%b idx=%0d exp 1/0", vld8, idx8);
    end
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid_hold;
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h10, 1'b0);
    drive(1'b1, 8'h30, 1'b1);
    checks++;
    if (vld8 !== 1'b0 || idx8 !== 3'd0) begin
      errors++; $display("FAIL midhold_reset got vld=%b idx=%0d exp 0/0", vld8, idx8);
    end
    drive(1'b0, 8'h30, 1'b0);
    checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd4) begin
      errors++; $display("FAIL midhold_regrant got vld=%b idx=%0d exp 1/4", vld8, idx8);
    end
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_req_num5;
    drive(1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 8'h1F, 1'b1);
      checks++;
      if (vld5 !== 1'b1 || idx5 !== 3'(k % 5)) begin
        errors++; $display("FAIL n5_seq[%0d] got vld=%b idx=%0d exp vld=1 idx=%0d", k, vld5, idx5, k % 5);
      end
    end
  endtask

  task automatic test_random;
    drive(1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 600; k++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(3) == 0) r = '0;
      drive(($urandom_range(49) == 0), r, ($urandom_range(2) != 0));
      checks++;
      if (vld8 !== m8_vld || busy8 !== m8_vld || idx8 !== 3'(m8_idx)) begin
        errors++;
        $display("FAIL rand8[%0d] got vld=%b busy=%b idx=%0d exp vld=%b idx=%0d",
                 k, vld8, busy8, idx8, m8_vld, m8_idx);
      end
      checks++;
      if (vld5 !== m5_vld || busy5 !== m5_vld || idx5 !== 3'(m5_idx) || idx5 > 3'd4) begin
        errors++;
        $display("FAIL rand5[%0d] got vld=%b busy=%b idx=%0d exp vld=%b idx=%0d",
                 k, vld5, busy5, idx5, m5_vld, m5_idx);
      end
    end
  endtask

  initial begin
    m8_vld = 0; m8_idx = 0; m8_ptr = 0;
    m5_vld = 0; m5_idx = 0; m5_ptr = 0;
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_hold;
    test_wrap;
    test_reset_mid_hold;
    test_req_num5;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
